// File: rtl/clz_seq_ctrl.sv
// Multi-cycle count-leading-zeros sequencer: scans a latched operand
// MSB-chunk-first through one CHUNK-bit CLZ tree, stopping at the first set chunk.
module clz_seq_ctrl #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [0:WIDTH-1]        in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [0:$clog2(WIDTH)]  out_count,
    output logic                    out_zero,
    output logic                    busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = $clog2(WIDTH) + 1;
    localparam int LC     = $clog2(CHUNK);
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t             state;
    logic [0:WIDTH-1]   op;
    logic [CNT_W-1:0]   acc;
    logic [IDX_W-1:0]   idx;
    logic [0:CNT_W-1]   cnt_q;
    logic               zero_q;

    logic [0:CHUNK-1]   chunk;
    logic [LC-1:0]      clz_val;
    logic               chunk_zero;

    // Operand shifts left each step, so the chunk under test is always on top.
    assign chunk = op[0:CHUNK-1];

    // Merge tree: each node keeps an all-zero flag and the count inside it.
    for (genvar l = 0; l <= LC; l++) begin : g_lvl
        localparam int NN = CHUNK >> l;
        logic [NN-1:0] z;
        logic [LC-1:0] c [NN];
        if (l == 0) begin : g_leaf
            for (genvar n = 0; n < NN; n++) begin : g_n
                assign z[n] = ~chunk[n];
                assign c[n] = '0;
            end
        end else begin : g_merge
            for (genvar n = 0; n < NN; n++) begin : g_n
                assign z[n] = g_lvl[l-1].z[2*n] & g_lvl[l-1].z[2*n+1];
                assign c[n] = g_lvl[l-1].z[2*n]
                            ? g_lvl[l-1].c[2*n+1] + LC'(1 << (l - 1))
                            : g_lvl[l-1].c[2*n];
            end
        end
    end

    assign clz_val    = g_lvl[LC].c[0];
    assign chunk_zero = g_lvl[LC].z[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op     <= '0;
            acc    <= '0;
            idx    <= '0;
            cnt_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        op    <= in_data;
                        acc   <= '0;
                        idx   <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (!chunk_zero) begin
                        cnt_q  <= acc + CNT_W'(clz_val);
                        zero_q <= 1'b0;
                        state  <= DONE;
                    end else if (idx == IDX_W'(NCHUNK - 1)) begin
                        cnt_q  <= CNT_W'(WIDTH);
                        zero_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        acc <= acc + CNT_W'(CHUNK);
                        idx <= idx + 1'b1;
                        op  <= op << CHUNK;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_count = cnt_q;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_clz_seq_ctrl.sv
// Self-checking bench for clz_seq_ctrl: directed table, backpressure,
// mid-scan reset and randomized operands against an arithmetic model.
module tb_clz_seq_ctrl;

    localparam int WIDTH  = 64;
    localparam int CHUNK  = 16;
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = $clog2(WIDTH) + 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [0:WIDTH-1]   in_data;
    logic               out_valid;
    logic               out_ready;
    logic [0:CNT_W-1]   out_count;
    logic               out_zero;
    logic               busy;

    int nvec = 0;
    int nmis = 0;

    clz_seq_ctrl #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .out_zero(out_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        int          cnt;
        bit          zero;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: count zeros from the top bit; latency is the index of the
    // first non-zero chunk plus one, capped at the chunk count.
    function automatic int ref_clz(input logic [63:0] d);
        for (int i = 63; i >= 0; i--)
            if (d[i]) return 63 - i;
        return 64;
    endfunction

    function automatic int ref_lat(input int cnt);
        int c;
        c = cnt / CHUNK;
        if (c > NCHUNK - 1) c = NCHUNK - 1;
        return c + 1;
    endfunction

    task automatic run_op(input string nm, input logic [63:0] d,
                          input int ecnt, input bit ezero, input int elat,
                          input int hold);
        int lat;
        logic [63:0] cnt_seen;
        chk({nm, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        chk({nm, "_busy"}, busy, 1);
        lat = 1;
        while (!out_valid && lat < 20) begin
            in_data = {$urandom, $urandom};
            tick();
            if (!out_valid) lat++;
        end
        chk({nm, "_latency"}, lat, elat);
        chk({nm, "_count"}, out_count, ecnt);
        chk({nm, "_zero"}, out_zero, ezero);
        cnt_seen = out_count;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({nm, "_hold"}, {out_valid, out_zero, out_count},
                {1'b1, ezero, cnt_seen[CNT_W-1:0]});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({nm, "_idle"}, {in_ready, out_valid, busy}, 3'b100);
    endtask

    vec_t tbl [6];

    initial begin
        logic [63:0] v;
        int lz, c;

        tbl[0] = '{64'h8000_0000_0000_0000,  0, 1'b0, 1};
        tbl[1] = '{64'h0000_0000_0001_0000, 47, 1'b0, 3};
        tbl[2] = '{64'h0000_0000_0000_0001, 63, 1'b0, 4};
        tbl[3] = '{64'h0000_0000_0000_0000, 64, 1'b1, 4};
        tbl[4] = '{64'h0000_4000_0000_0000, 17, 1'b0, 2};
        tbl[5] = '{64'h0001_FFFF_FFFF_FFFF, 15, 1'b0, 1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_flags", {in_ready, out_valid, busy}, 3'b100);
        chk("reset_count", {out_zero, out_count}, '0);

        for (int i = 0; i < 6; i++)
            run_op($sformatf("tbl%0d", i), tbl[i].data, tbl[i].cnt,
                   tbl[i].zero, tbl[i].lat, i % 2);

        // Result pending while a new operand is offered.
        in_valid = 1'b1;
        in_data  = 64'h0000_0000_0001_0000;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("bp_valid", out_valid, 1);
        in_valid = 1'b1;
        in_data  = 64'h8000_0000_0000_0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_stall", {out_valid, in_ready, out_zero, out_count},
                {1'b1, 1'b0, 1'b0, 7'd47});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release", {in_ready, out_valid}, 2'b10);
        tick();
        in_valid = 1'b0;
        chk("bp_accept", {busy, in_ready}, 2'b10);
        tick();
        chk("bp_new_result", {out_valid, out_zero, out_count},
            {1'b1, 1'b0, 7'd0});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Leave a non-zero count behind, then reset in the 2nd scan cycle.
        run_op("pre_rst", 64'h0000_0000_0000_0001, 63, 1'b0, 4, 0);
        in_valid = 1'b1;
        in_data  = 64'h0;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_flags", {out_valid, busy, in_ready}, 3'b001);
        chk("mid_rst_count", {out_zero, out_count}, '0);
        c = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid || busy) c++;
        end
        chk("mid_rst_no_result", c, 0);

        for (int n = 0; n < 150; n++) begin
            lz = $urandom_range(0, 64);
            v  = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
            v  = (lz == 64) ? 64'h0 : (v >> lz);
            c  = ref_clz(v);
            run_op($sformatf("rnd%0d", n), v, c, c == 64, ref_lat(c),
                   $urandom_range(0, 3));
            for (int k = $urandom_range(0, 2); k > 0; k--) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
